// File: rtl/pad_input_conditioner.sv
// Input conditioning between pad ring and core: synchronises and debounces the bidir inputs,
// generates edge pulses, and captures the pad data bus on a debounced strobe (bidir bit 0).
module pad_input_conditioner #(
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned BIDIR_W         = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic               pad_clk,
   input  logic               pad_rst,
   input  logic [DATA_W-1:0]  pad_data_in,
   input  logic [BIDIR_W-1:0] bidir_inputs_from_pad,
   input  logic               data_ready,
   input  logic               overrun_clr,
   output logic [BIDIR_W-1:0] bidir_clean,
   output logic [BIDIR_W-1:0] bidir_rise,
   output logic [BIDIR_W-1:0] bidir_fall,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_valid,
   output logic               overrun
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {StIdle, StHold} state_t;

   logic [BIDIR_W-1:0] bsync_q [SYNC_STAGES];
   logic [BIDIR_W-1:0] bsync_d [SYNC_STAGES];
   logic [DATA_W-1:0]  dsync_q [SYNC_STAGES];
   logic [DATA_W-1:0]  dsync_d [SYNC_STAGES];
   logic [CNT_W-1:0]   cnt_q   [BIDIR_W];
   logic [CNT_W-1:0]   cnt_d   [BIDIR_W];
   logic [BIDIR_W-1:0] clean_q, clean_d;
   logic [BIDIR_W-1:0] rise_q, rise_d;
   logic [BIDIR_W-1:0] fall_q, fall_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               overrun_q, overrun_d;
   state_t             state_q, state_d;

   logic [BIDIR_W-1:0] s;
   logic [DATA_W-1:0]  d_sync;
   logic               strobe_evt;

   assign s      = bsync_q[SYNC_STAGES-1];
   assign d_sync = dsync_q[SYNC_STAGES-1];

   always_comb begin
      bsync_d[0] = bidir_inputs_from_pad;
      dsync_d[0] = pad_data_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         bsync_d[k] = bsync_q[k-1];
         dsync_d[k] = dsync_q[k-1];
      end
   end

   // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles before clean follows s.
   always_comb begin
      clean_d = clean_q;
      for (int i = 0; i < BIDIR_W; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == clean_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]   = '0;
            clean_d[i] = s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      rise_d = clean_d & ~clean_q;
      fall_d = ~clean_d & clean_q;
   end

   assign strobe_evt = clean_d[0] & ~clean_q[0];

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (strobe_evt) begin
               data_d  = d_sync;
               state_d = StHold;
            end
         end
         StHold: begin
            if (data_ready && strobe_evt) begin
               data_d = d_sync;
            end else if (data_ready) begin
               state_d = StIdle;
            end else if (strobe_evt) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge pad_clk or posedge pad_rst) begin
      if (pad_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            bsync_q[k] <= '0;
            dsync_q[k] <= '0;
         end
         for (int i = 0; i < BIDIR_W; i++) begin
            cnt_q[i] <= '0;
         end
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
         state_q   <= StIdle;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            bsync_q[k] <= bsync_d[k];
            dsync_q[k] <= dsync_d[k];
         end
         for (int i = 0; i < BIDIR_W; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         clean_q   <= clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign bidir_clean = clean_q;
   assign bidir_rise  = rise_q;
   assign bidir_fall  = fall_q;
   assign data_out    = data_q;
   assign data_valid  = (state_q == StHold);
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed self-checking bench for pad_input_conditioner with default parameters.
module tb_pad_input_conditioner;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pad_data;
   logic [3:0]  bidir;
   logic        ready;
   logic        clr;
   logic [3:0]  clean, rise, fall;
   logic [15:0] dout;
   logic        valid;
   logic        ovr;

   int n_cmp = 0;
   int n_err = 0;

   pad_input_conditioner dut (
      .pad_clk               (clk),
      .pad_rst               (rst),
      .pad_data_in           (pad_data),
      .bidir_inputs_from_pad (bidir),
      .data_ready            (ready),
      .overrun_clr           (clr),
      .bidir_clean           (clean),
      .bidir_rise            (rise),
      .bidir_fall            (fall),
      .data_out              (dout),
      .data_valid            (valid),
      .overrun               (ovr)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      int saw;
      int nrise;
      int nfall;

      // Reset with strobe and data already high at the pad
      rst = 1'b1; bidir = 4'b0001; pad_data = 16'hFFFF; ready = 1'b0; clr = 1'b0;
      tick(2);
      check("rst_clean", 32'(clean), 32'h0);
      check("rst_rise", 32'(rise), 32'h0);
      check("rst_fall", 32'(fall), 32'h0);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_ovr", 32'(ovr), 32'h0);
      rst = 1'b0;
      tick(5);
      check("post_rst_e4_clean", 32'(clean), 32'h0);
      check("post_rst_e4_valid", 32'(valid), 32'h0);
      tick(1);
      check("post_rst_e5_clean", 32'(clean), 32'h1);
      check("post_rst_e5_rise", 32'(rise), 32'h1);
      check("post_rst_e5_valid", 32'(valid), 32'h1);
      check("post_rst_e5_dout", 32'(dout), 32'hFFFF);
      tick(1);
      check("post_rst_rise_end", 32'(rise), 32'h0);
      ready = 1'b1;
      tick(1);
      check("post_rst_accept", 32'(valid), 32'h0);
      ready = 1'b0;
      bidir = 4'b0000;
      tick(6);
      check("strobe_fall", 32'(fall), 32'h1);
      check("strobe_fall_clean", 32'(clean), 32'h0);
      tick(1);
      check("strobe_fall_end", 32'(fall), 32'h0);

      // Clean capture
      pad_data = 16'hA5C3; bidir = 4'b0001;
      tick(5);
      check("cap_e4_rise", 32'(rise), 32'h0);
      tick(1);
      check("cap_e5_rise", 32'(rise), 32'h1);
      check("cap_dout", 32'(dout), 32'hA5C3);
      check("cap_valid", 32'(valid), 32'h1);
      tick(1);
      check("cap_rise_once", 32'(rise), 32'h0);
      tick(3);
      check("cap_valid_hold", 32'(valid), 32'h1);
      ready = 1'b1;
      tick(1);
      check("cap_accept", 32'(valid), 32'h0);
      check("cap_ovr", 32'(ovr), 32'h0);
      ready = 1'b0;
      bidir = 4'b0000;
      tick(7);
      check("cap_release", 32'(clean), 32'h0);

      // Glitch of 3 cycles on bit 2 is filtered
      bidir = 4'b0100;
      tick(3);
      bidir = 4'b0000;
      saw = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         saw = saw | int'(rise[2]) | int'(fall[2]) | int'(clean[2]);
      end
      check("glitch_filtered", 32'(saw), 32'h0);

      // 4-cycle pulse on bit 2 passes; returns low 4 cycles later
      bidir = 4'b0100;
      tick(4);
      bidir = 4'b0000;
      tick(2);
      check("pulse4_clean", 32'(clean), 32'h4);
      check("pulse4_rise", 32'(rise), 32'h4);
      nrise = 0; nfall = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         nrise += int'(rise[2]);
         nfall += int'(fall[2]);
      end
      check("pulse4_extra_rise", 32'(nrise), 32'h0);
      check("pulse4_one_fall", 32'(nfall), 32'h1);
      check("pulse4_no_capture", 32'(valid), 32'h0);

      // Overrun
      pad_data = 16'h1111; bidir = 4'b0001;
      tick(6);
      check("ovr_cap1_dout", 32'(dout), 32'h1111);
      check("ovr_cap1_valid", 32'(valid), 32'h1);
      bidir = 4'b0000;
      tick(7);
      pad_data = 16'h2222; bidir = 4'b0001;
      tick(6);
      check("ovr_dout_kept", 32'(dout), 32'h1111);
      check("ovr_set", 32'(ovr), 32'h1);
      check("ovr_valid", 32'(valid), 32'h1);
      bidir = 4'b0000;
      tick(7);
      pad_data = 16'h4444; bidir = 4'b0001;
      tick(5);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ovr_set_wins", 32'(ovr), 32'h1);
      check("ovr_dout_kept2", 32'(dout), 32'h1111);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ovr_cleared", 32'(ovr), 32'h0);

      // Back-to-back accept and capture
      bidir = 4'b0000;
      tick(7);
      pad_data = 16'h3333; bidir = 4'b0001;
      tick(5);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("b2b_dout", 32'(dout), 32'h3333);
      check("b2b_valid", 32'(valid), 32'h1);
      check("b2b_ovr", 32'(ovr), 32'h0);

      // Mid-operation reset
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check("mid_idle", 32'(valid), 32'h0);
      bidir = 4'b0000;
      tick(7);
      pad_data = 16'hBEEF; bidir = 4'b0001;
      tick(6);
      check("mid_dout", 32'(dout), 32'hBEEF);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid), 32'h0);
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_clean", 32'(clean), 32'h0);
      tick(1);
      rst = 1'b0;
      saw = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         saw = saw | int'(fall != 4'b0000);
      end
      check("mid_no_fall", 32'(saw), 32'h0);
      check("mid_rerise", 32'(rise), 32'h1);
      check("mid_recapture", 32'(dout), 32'hBEEF);
      check("mid_revalid", 32'(valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
